// File: rtl/dmem_stage_if.sv
// Backing-memory request/acknowledge bus between the MEM-stage cache and the
// slow data memory.
//   master (cache side) : drives mem_req, mem_we, mem_addr, mem_wdata
//                         samples mem_rdata, mem_ack
//   slave  (memory side): the mirror image
// mem_rdata is valid in the cycle mem_ack pulses; mem_ack is a one-cycle pulse.
interface dmem_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dmem_stage.sv
// MEM-stage data-memory access block.
// Direct-mapped, one-word-per-line, write-through, no-write-allocate cache in
// front of a slow backing memory reached over dmem_stage_if.
//
// Ports:
//   clk, rstn    pipeline clock (rising edge), async active-low reset
//   i_memread    load request from EX/MEM
//   i_memwrite   store request from EX/MEM (wins over i_memread)
//   i_addr       byte address, bits [1:0] ignored
//   i_wdata      store data
//   o_rdata      load data to MEM/WB (0 when there is nothing to return)
//   hit          1 = access complete or no access; 0 = stall the pipeline
//   mem          master side of the backing-memory req/ack bus
//   o_hit_cnt    (DMEM_STATS_EN only) saturating count of IDLE read hits
//   o_miss_cnt   (DMEM_STATS_EN only) saturating count of read misses
//
// Optional feature macro: DMEM_STATS_EN adds the two statistics counters.
module dmem_stage #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_memread,
  input  logic              i_memwrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              hit,
  dmem_stage_if.master      mem
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Cache arrays; only the valid bits need a reset value.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  // Load data captured on a read-miss fill, presented during RESP.
  logic [31:0] fill;
  // Remembers whether the outstanding access was a read, so RESP knows
  // whether to present fill or zero.
  logic        resp_rd;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag_in;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               acc_rd;
  logic               acc_wr;
  logic               lookup_hit;
  logic               rd_hit;
  logic               start_rd;
  logic               start_wr;
  logic               ack;
  logic               unused_addr_lsb;

  // Lookup address split from the live pipeline inputs.
  assign idx    = i_addr[INDEX_W+1:2];
  assign tag_in = i_addr[ADDR_W-1:INDEX_W+2];

  // While a request is outstanding the registered bus address identifies the
  // line to fill, so no separate copy of index/tag is kept.
  assign fill_idx = mem.mem_addr[INDEX_W+1:2];
  assign fill_tag = mem.mem_addr[ADDR_W-1:INDEX_W+2];

  // Byte offset within the word plays no role in a word-granular cache.
  assign unused_addr_lsb = ^i_addr[1:0];

  assign acc_wr     = i_memwrite;
  assign acc_rd     = i_memread & ~i_memwrite;
  assign lookup_hit = valid[idx] && (tag_arr[idx] == tag_in);

  assign rd_hit   = (state == IDLE) && acc_rd && lookup_hit;
  assign start_rd = (state == IDLE) && acc_rd && !lookup_hit;
  assign start_wr = (state == IDLE) && acc_wr;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack = mem.mem_ack && mem.mem_req;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the combinational hit / load-data outputs.
  always_comb begin
    state_nx = state;
    hit      = 1'b0;
    o_rdata  = 32'd0;
    case (state)
      IDLE: begin
        hit = ~start_wr & ~start_rd;
        if (rd_hit) begin
          o_rdata = data_arr[idx];
        end
        if (start_wr) begin
          state_nx = WR_THRU;
        end else if (start_rd) begin
          state_nx = RD_MISS;
        end
      end
      RD_MISS: begin
        if (ack) begin
          state_nx = RESP;
        end
      end
      WR_THRU: begin
        if (ack) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        hit = 1'b1;
        if (resp_rd) begin
          o_rdata = fill;
        end
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // The pipeline must not advance while the block is held in reset.
    if (!rstn) begin
      hit     = 1'b0;
      o_rdata = 32'd0;
    end
  end

  // Backing-memory bus registers, valid bits and the fill register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 32'd0;
      valid         <= '0;
      fill          <= 32'd0;
      resp_rd       <= 1'b0;
    end else begin
      if (start_wr) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= 1'b1;
        mem.mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
        mem.mem_wdata <= i_wdata;
        resp_rd       <= 1'b0;
      end else if (start_rd) begin
        mem.mem_req  <= 1'b1;
        mem.mem_we   <= 1'b0;
        mem.mem_addr <= {i_addr[ADDR_W-1:2], 2'b00};
        resp_rd      <= 1'b1;
      end

      if ((state == RD_MISS) && ack) begin
        valid[fill_idx] <= 1'b1;
        fill            <= mem.mem_rdata;
        mem.mem_req     <= 1'b0;
      end

      if ((state == WR_THRU) && ack) begin
        mem.mem_req <= 1'b0;
        mem.mem_we  <= 1'b0;
      end
    end
  end

  // Tag/data arrays: write-hit update in IDLE, line fill on read-miss ack.
  // A write miss leaves the arrays untouched (no allocation).
  always_ff @(posedge clk) begin
    if (start_wr && lookup_hit) begin
      data_arr[idx] <= i_wdata;
    end
    if ((state == RD_MISS) && ack) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem.mem_rdata;
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating hit/miss statistics; writes are counted in neither.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_hit_cnt  <= 32'd0;
      o_miss_cnt <= 32'd0;
    end else begin
      if (rd_hit && (o_hit_cnt != 32'hFFFF_FFFF)) begin
        o_hit_cnt <= o_hit_cnt + 32'd1;
      end
      if (start_rd && (o_miss_cnt != 32'hFFFF_FFFF)) begin
        o_miss_cnt <= o_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: directed test-plan sequence followed by
// randomized loads/stores, checked cycle by cycle against a transaction-level
// model of the cache (resident word address per line + flat memory image).
module tb_dmem_stage;

  localparam int unsigned LINES   = 16;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INDEX_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_memread;
  logic              i_memwrite;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic              hit;
`ifdef DMEM_STATS_EN
  logic [31:0]       o_hit_cnt;
  logic [31:0]       o_miss_cnt;
`endif

  dmem_stage_if #(.ADDR_W(ADDR_W)) mif ();

  dmem_stage #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_memread  (i_memread),
    .i_memwrite (i_memwrite),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .hit        (hit),
    .mem        (mif)
`ifdef DMEM_STATS_EN
    ,
    .o_hit_cnt  (o_hit_cnt),
    .o_miss_cnt (o_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void chk(input string name, input int txn,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, exp);
  endfunction

  // Memory image: explicit contents where written, a fixed pattern elsewhere.
  logic [31:0] bmem [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  // Backing-memory responder: acks on the ack_delay-th cycle of a request.
  int   ack_delay = 1;
  int   req_cycles = 0;
  logic spurious_ack = 1'b0;

  always @(posedge clk) begin
    #2;
    if (mif.mem_req) begin
      req_cycles++;
      mif.mem_ack   = (req_cycles == ack_delay);
      mif.mem_rdata = mem_val(mif.mem_addr);
    end else begin
      req_cycles    = 0;
      mif.mem_ack   = spurious_ack;
      mif.mem_rdata = 32'hBAD0_BAD0;
    end
  end

  // Per-cycle expectations, consumed by the compare process one per cycle.
  typedef struct {
    int          txn;
    logic        hit;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        wd;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push(input int txn, input logic h, input logic [31:0] rd,
                               input logic rq, input logic we, input logic [31:0] ad,
                               input logic wd, input logic [31:0] wdat);
    exp_t e;
    e.txn = txn; e.hit = h; e.rdata = rd; e.req = rq;
    e.we = we; e.addr = ad; e.wd = wd; e.wdata = wdat;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("hit", e.txn, 32'(hit), 32'(e.hit));
      chk("o_rdata", e.txn, o_rdata, e.rdata);
      chk("mem_req", e.txn, 32'(mif.mem_req), 32'(e.req));
      if (e.req) begin
        chk("mem_we", e.txn, 32'(mif.mem_we), 32'(e.we));
        chk("mem_addr", e.txn, mif.mem_addr, e.addr);
      end
      if (e.wd) chk("mem_wdata", e.txn, mif.mem_wdata, e.wdata);
    end
  end

  // Cache model: which word address each line holds, if any.
  logic        res_v [LINES];
  logic [31:0] res_a [LINES];
  int          m_hits = 0;
  int          m_miss = 0;
  int          txn_id = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) res_v[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic idle(input int n);
    i_memread  = 1'b0;
    i_memwrite = 1'b0;
    for (int i = 0; i < n; i++) push(txn_id, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(n);
  endtask

  // One pipeline access; low = cycles hit stays 0, resp = data returned.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int n,
                        output int low, output logic [31:0] resp);
    logic [31:0] wa;
    int          ix;
    logic        er, ew, mh;
    wa = {addr[31:2], 2'b00};
    ix = int'(wa[INDEX_W+1:2]);
    ew = wr;
    er = rd & ~wr;
    mh = er && res_v[ix] && (res_a[ix] == wa);
    txn_id++;
    i_memread  = rd;
    i_memwrite = wr;
    i_addr     = addr;
    i_wdata    = wd;
    ack_delay  = n;
    if (!er && !ew) begin
      low = 0; resp = 32'd0;
      push(txn_id, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1);
    end else if (mh) begin
      low = 0; resp = mem_val(wa);
      m_hits++;
      push(txn_id, 1'b1, resp, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1);
    end else begin
      low = n + 1;
      if (ew) begin
        bmem[wa] = wd;
        resp = 32'd0;
      end else begin
        resp = mem_val(wa);
        res_v[ix] = 1'b1;
        res_a[ix] = wa;
        m_miss++;
      end
      push(txn_id, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int k = 1; k <= n; k++) push(txn_id, 1'b0, 32'd0, 1'b1, ew, wa, ew, wd);
      push(txn_id, 1'b1, resp, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      step(n + 2);
    end
    i_memread  = 1'b0;
    i_memwrite = 1'b0;
  endtask

  int          low;
  logic [31:0] r;

  initial begin
    rstn       = 1'b0;
    i_memread  = 1'b0;
    i_memwrite = 1'b0;
    i_addr     = '0;
    i_wdata    = 32'd0;
    model_reset();
    bmem[32'h44] = 32'hDEAD_BEEF;

    // Reset held three cycles: stalled, no request, zero data.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(3);
    rstn = 1'b1;
`ifdef DMEM_STATS_EN
    chk("hit_cnt_rst", 0, o_hit_cnt, 32'd0);
    chk("miss_cnt_rst", 0, o_miss_cnt, 32'd0);
`endif
    idle(2);

    // Cold miss, ack on the 3rd request cycle.
    access(1'b1, 1'b0, 32'h44, 32'd0, 3, low, r);
    chk("pin_cold_low", txn_id, 32'(low), 32'd4);
    chk("pin_cold_data", txn_id, r, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h44, 32'd0, 3, low, r);
    chk("pin_rehit_low", txn_id, 32'(low), 32'd0);
    chk("pin_rehit_data", txn_id, r, 32'hDEAD_BEEF);

    // Write-through update of a resident line.
    access(1'b0, 1'b1, 32'h44, 32'h1234_5678, 2, low, r);
    chk("pin_wr_low", txn_id, 32'(low), 32'd3);
    access(1'b1, 1'b0, 32'h47, 32'd0, 2, low, r);
    chk("pin_wrhit_low", txn_id, 32'(low), 32'd0);
    chk("pin_wrhit_data", txn_id, r, 32'h1234_5678);

    // No-write-allocate, then conflict eviction on index 1.
    access(1'b0, 1'b1, 32'h84, 32'hCAFE_0084, 1, low, r);
    chk("pin_wrmiss_low", txn_id, 32'(low), 32'd2);
    access(1'b1, 1'b0, 32'h84, 32'd0, 2, low, r);
    chk("pin_noalloc_low", txn_id, 32'(low), 32'd3);
    chk("pin_noalloc_data", txn_id, r, 32'hCAFE_0084);
    access(1'b1, 1'b0, 32'h44, 32'd0, 1, low, r);
    chk("pin_evict_low", txn_id, 32'(low), 32'd2);
    chk("pin_evict_data", txn_id, r, 32'h1234_5678);

    // Read+write together takes the write path only.
    access(1'b1, 1'b1, 32'h48, 32'h55AA_55AA, 1, low, r);
    chk("pin_prio_data", txn_id, r, 32'd0);

    // Spurious ack in IDLE is ignored.
    spurious_ack = 1'b1;
    idle(1);
    spurious_ack = 1'b0;
    idle(1);
    access(1'b1, 1'b0, 32'h44, 32'd0, 1, low, r);
    chk("pin_spur_low", txn_id, 32'(low), 32'd0);
    chk("pin_spur_data", txn_id, r, 32'h1234_5678);

    // Reset in the middle of a read miss.
    txn_id++;
    i_memread = 1'b1;
    i_addr    = 32'h200;
    ack_delay = 1000;
    push(txn_id, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    push(txn_id, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 1'b0, 32'd0);
    step(2);
    rstn      = 1'b0;
    i_memread = 1'b0;
    push(txn_id, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    push(txn_id, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(2);
    rstn = 1'b1;
    model_reset();
`ifdef DMEM_STATS_EN
    chk("hit_cnt_midrst", txn_id, o_hit_cnt, 32'd0);
    chk("miss_cnt_midrst", txn_id, o_miss_cnt, 32'd0);
`endif
    spurious_ack = 1'b1;
    idle(1);
    spurious_ack = 1'b0;
    idle(1);
    access(1'b1, 1'b0, 32'h200, 32'd0, 2, low, r);
    chk("pin_rstmiss_low", txn_id, 32'(low), 32'd3);
    access(1'b1, 1'b0, 32'h44, 32'd0, 1, low, r);
    chk("pin_rst_inval_low", txn_id, 32'(low), 32'd2);

    // Randomized traffic over a small address pool to provoke hits/conflicts.
    for (int t = 0; t < 400; t++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 99));
      a  = (32'($urandom_range(0, 39)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      if (op < 50)      access(1'b1, 1'b0, a, $urandom, int'($urandom_range(1, 4)), low, r);
      else if (op < 85) access(1'b0, 1'b1, a, $urandom, int'($urandom_range(1, 4)), low, r);
      else if (op < 95) access(1'b1, 1'b1, a, $urandom, int'($urandom_range(1, 4)), low, r);
      else              access(1'b0, 1'b0, a, $urandom, 1, low, r);
    end
    idle(2);

`ifdef DMEM_STATS_EN
    chk("hit_cnt_final", txn_id, o_hit_cnt, 32'(m_hits));
    chk("miss_cnt_final", txn_id, o_miss_cnt, 32'(m_miss));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- MEM-stage data-memory access block. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the load/store command, address and store data from EX/MEM. Produces the load data `o_rdata` that feeds MEM/WB's `iread_data_mem`, plus the `hit` signal that gates MEM/WB and upstream stages.
- Contains a direct-mapped, one-word-per-line, write-through, no-write-allocate cache in front of a slow backing memory with a req/ack handshake.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2; INDEX_W = log2(LINES).
- ADDR_W, 32, byte-address width; TAG_W = ADDR_W - INDEX_W - 2.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_memread  in  1  load request from EX/MEM.
- i_memwrite  in  1  store request from EX/MEM.
- i_addr  in  ADDR_W  byte address (ALU result); bits [1:0] ignored.
- i_wdata  in  32  store data.
- o_rdata  out  32  load data to MEM/WB.
- hit  out  1  1 = access complete / no access, pipeline may advance; 0 = stall.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - index = i_addr[INDEX_W+1:2]; tag = i_addr[ADDR_W-1:INDEX_W+2].
  - Arrays: valid[LINES], tag[LINES], data[LINES].
- States: IDLE, RD_MISS, WR_THRU, RESP.
- Effective access:
  - write = i_memwrite (priority).
  - read = i_memread & ~i_memwrite.
  - none otherwise.
- IDLE:
  - No access: hit=1, o_rdata=0.
  - Read with valid & tag match (lookup hit): hit=1, o_rdata=data[index] combinationally, zero latency.
  - Read miss: hit=0. Next edge → RD_MISS, with mem_req=1, mem_we=0, mem_addr=aligned i_addr.
  - Write (hit or miss): hit=0. Next edge → WR_THRU, with mem_req=1, mem_we=1, mem_addr, mem_wdata=i_wdata.
  - On a write tag match, the line's data is updated at that same edge; a write miss allocates nothing.
- RD_MISS:
  - hit=0; mem_req held.
  - On the mem_ack edge: valid=1, tag and data written, fill register = mem_rdata, mem_req→0, state → RESP.
- WR_THRU:
  - hit=0; mem_req/mem_we/mem_addr/mem_wdata held.
  - On the mem_ack edge: mem_req→0, mem_we→0, state → RESP.
- RESP (exactly one cycle):
  - hit=1; o_rdata = fill register after a read, 0 after a write.
  - State → IDLE. A new access is not evaluated in RESP; the pipeline advances on this edge.
- Latency:
  - Read hit: 0 stall cycles.
  - Miss or write: 1 issue cycle + N wait cycles + RESP; hit is low for N+1 cycles when ack arrives N cycles after mem_req rises.
  - Fastest case: ack on the first req cycle gives hit low for 2 cycles.
- Input stability:
  - i_* are held stable by the stalled pipeline while hit=0. The block samples only in IDLE and uses registered copies thereafter.
- Handshake:
  - mem_ack while mem_req=0 is ignored.
  - mem_req never drops before ack.
  - Back-to-back requests are separated by at least RESP plus one IDLE cycle.
- Reset (any time, including mid-miss):
  - All valid cleared; state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill register=0.
  - hit is forced 0 and o_rdata 0 while rstn=0.
  - An ack arriving after reset release for an aborted request is ignored.

Optional Feature:
- Macro `DMEM_STATS_EN`.
- Defined: adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0], both saturating at 0xFFFFFFFF and cleared by reset.
  - o_hit_cnt increments once per IDLE read hit on each edge where hit=1 with a read.
  - o_miss_cnt increments once per IDLE→RD_MISS transition.
  - Writes count in neither.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rstn low 3 cycles → hit=0, mem_req=0, o_rdata=0. After release with no access → hit=1.
- Cold read miss:
  - Stimulus: read 0x00000044; memory acks on the 3rd req cycle with 0xDEADBEEF.
  - Response: mem_addr=0x44, mem_we=0, hit low 4 cycles, then RESP with o_rdata=0xDEADBEEF.
  - Immediate re-read of 0x44 → hit=1, same cycle, no mem_req.
- Write-through update:
  - Stimulus: after the 0x44 fill, write 0x12345678 to 0x44.
  - Response: mem_we=1, mem_wdata=0x12345678, until ack. A subsequent read of 0x44 hits with 0x12345678.
- No-write-allocate and conflict:
  - Write to 0x84 (miss) → one memory write, no allocation.
  - Read of 0x84 then misses. With LINES=16, 0x84 and 0x44 map to index 1; reading 0x84 evicts 0x44, so the next read of 0x44 misses again.
- Priority and spurious ack:
  - i_memread=i_memwrite=1 → write path only (mem_we=1).
  - mem_ack pulsed in IDLE → no state change.
- Reset mid-miss:
  - Stimulus: assert rstn during RD_MISS, release, then ack arrives.
  - Response: mem_req=0, no fill occurs, and a read of that address misses again.
  - With DMEM_STATS_EN, counters read 0 after reset.
